// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the PmodSSD scan controller: FSM state encoding,
// the all-off segment pattern and the hex -> seven-segment lookup table.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
// ---------------------------------------------------------------------------
package ssd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHOW_R  = 3'd1,
    ST_BLANK_R = 3'd2,
    ST_SHOW_L  = 3'd3,
    ST_BLANK_L = 3'd4
  } ssd_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Element [n] is the pattern for hex digit n (leftmost literal is digit F).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/ssd_if.sv
// ---------------------------------------------------------------------------
// ssd_if
// Control/data bundle between the register core (master) and the scan
// controller (slave).
//   enable, brightness, value, value_valid : master -> slave
//   value_ready, seg, digit_sel,
//   frame_tick, busy                       : slave -> master
// ---------------------------------------------------------------------------
interface ssd_if #(
  parameter int BRIGHT_W = 4
);
  logic                enable;
  logic [BRIGHT_W-1:0] brightness;
  logic [7:0]          value;
  logic                value_valid;
  logic                value_ready;
  logic [6:0]          seg;
  logic                digit_sel;
  logic                frame_tick;
  logic                busy;

  modport master (
    output enable, brightness, value, value_valid,
    input  value_ready, seg, digit_sel, frame_tick, busy
  );

  modport slave (
    input  enable, brightness, value, value_valid,
    output value_ready, seg, digit_sel, frame_tick, busy
  );
endinterface

// File: rtl/ssd_hex_decoder.sv
// ---------------------------------------------------------------------------
// ssd_hex_decoder
// Combinational 4-bit hex to 7-segment decoder.
//   i_hex : hex nibble
//   o_seg : {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg(i_hex);
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
// Scan/refresh controller for the two-digit PmodSSD display. One segment bus
// is time-multiplexed between the right (ones) and left (tens) digit, with a
// blank interval at the end of every slot against ghosting and PWM dimming
// while a digit is shown. New values arrive over a valid/ready handshake and
// only take effect on a frame boundary (or straight away while idle).
//   clk   : sole clock
//   reset : asynchronous, active-high
//   bus   : ssd_if slave (enable, brightness, value/valid/ready,
//           seg, digit_sel, frame_tick, busy)
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | display off, waiting for enable
// ST_SHOW_R  | right digit lit (PWM-gated)
// ST_BLANK_R | all segments off, digit_sel still right
// ST_SHOW_L  | left digit lit (PWM-gated)
// ST_BLANK_L | all segments off, last slot of the frame
// ---------------------------------------------------------------------------
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BRIGHT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  ssd_if.slave bus
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

  ssd_state_t          r_state;
  logic [CNT_W-1:0]    r_slot_cnt;
  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic [6:0]          r_seg;
  logic                r_digit_sel;
  logic [7:0]          r_disp;
  logic [7:0]          r_pend;
  logic                r_pend_full;

  logic                w_digit_sel_next;
  logic                w_show;
  logic                w_pwm_on;
  logic                w_frame_tick;
  logic                w_apply;
  logic                w_capture;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_dec;

  assign w_digit_sel_next = (r_state == ST_SHOW_L) || (r_state == ST_BLANK_L);
  assign w_show           = (r_state == ST_SHOW_R) || (r_state == ST_SHOW_L);
  assign w_pwm_on         = (r_pwm_cnt <= bus.brightness);
  // Last cycle of the frame; an enable drop here aborts the frame instead.
  assign w_frame_tick     = (r_state == ST_BLANK_L) && (r_slot_cnt == SLOT_LAST) && bus.enable;
  // Applying needs pend_full=1 and capturing needs pend_full=0, so the two
  // can never coincide.
  assign w_apply          = r_pend_full && (w_frame_tick || (r_state == ST_IDLE));
  assign w_capture        = bus.value_valid && !r_pend_full;
  assign w_nibble         = w_digit_sel_next ? r_disp[7:4] : r_disp[3:0];

  ssd_hex_decoder u_dec (
    .i_hex (w_nibble),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_slot_cnt  <= '0;
      r_seg       <= SEG_BLANK;
      r_digit_sel <= 1'b0;
    end else begin
      // Outputs follow the current state one cycle later, so digit_sel only
      // moves in the cycle where seg is already blank from the BLANK slot.
      r_seg       <= (w_show && w_pwm_on) ? w_seg_dec : SEG_BLANK;
      r_digit_sel <= w_digit_sel_next;

      if ((r_state != ST_IDLE) && !bus.enable) begin
        r_state    <= ST_IDLE;
        r_slot_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.enable) begin
              r_state    <= ST_SHOW_R;
              r_slot_cnt <= '0;
            end
          end
          ST_SHOW_R, ST_SHOW_L: begin
            if (r_slot_cnt == SHOW_LAST)
              r_state <= (r_state == ST_SHOW_R) ? ST_BLANK_R : ST_BLANK_L;
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
          end
          ST_BLANK_R, ST_BLANK_L: begin
            if (r_slot_cnt == SLOT_LAST) begin
              r_state    <= (r_state == ST_BLANK_R) ? ST_SHOW_L : ST_SHOW_R;
              r_slot_cnt <= '0;
            end else begin
              r_slot_cnt <= r_slot_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_slot_cnt <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pwm_cnt <= '0;
    else
      r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp      <= 8'h00;
      r_pend      <= 8'h00;
      r_pend_full <= 1'b0;
    end else if (w_apply) begin
      r_disp      <= r_pend;
      r_pend_full <= 1'b0;
    end else if (w_capture) begin
      r_pend      <= bus.value;
      r_pend_full <= 1'b1;
    end
  end

  assign bus.value_ready = !r_pend_full;
  assign bus.seg         = r_seg;
  assign bus.digit_sel   = r_digit_sel;
  assign bus.frame_tick  = w_frame_tick;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
module tb_ssd_scan_ctrl;

  localparam int DIV   = 16;
  localparam int BLK   = 4;
  localparam int BW    = 4;
  localparam int SHOW  = DIV - BLK;
  localparam int FRAME = 2 * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ssd_if #(.BRIGHT_W(BW)) bus ();

  ssd_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLK),
    .BRIGHT_W     (BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position within the frame counted in cycles since the
  // scan started, PWM phase as cycles since reset, plus the value slots.
  bit         m_run, m_pend_full, m_tick;
  int         m_pos, m_pwm;
  logic [7:0] m_disp, m_pend;
  logic [3:0] m_nib;
  logic [6:0] e_seg;
  bit         e_dig;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_pend_full = 0; m_pos = 0; m_pwm = 0;
      m_disp = 8'h00; m_pend = 8'h00; e_seg = 7'h00; e_dig = 0;
    end else begin
      m_tick = m_run && (m_pos == FRAME - 1) && bus.enable;
      m_nib  = (m_pos >= DIV) ? m_disp[7:4] : m_disp[3:0];
      e_seg  = (m_run && (m_pos % DIV) < SHOW && m_pwm <= int'(bus.brightness)) ? HEX_SEG[m_nib] : 7'h00;
      e_dig  = m_run && (m_pos >= DIV);
      if (m_pend_full && (!m_run || m_tick)) begin
        m_disp = m_pend; m_pend_full = 0;
      end else if (bus.value_valid && !m_pend_full) begin
        m_pend = bus.value; m_pend_full = 1;
      end
      if (!m_run) begin
        m_run = bus.enable; m_pos = 0;
      end else if (!bus.enable) begin
        m_run = 0; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      m_pwm = (m_pwm + 1) % 16;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("seg",         32'(bus.seg),         32'(e_seg));
    chk("digit_sel",   32'(bus.digit_sel),   32'(e_dig));
    chk("busy",        32'(bus.busy),        32'(m_run));
    chk("value_ready", 32'(bus.value_ready), 32'(!m_pend_full));
    chk("frame_tick",  32'(bus.frame_tick),  32'(m_run && m_pos == FRAME - 1 && bus.enable));
  end

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!bus.frame_tick && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tick_timeout", 32'(bus.frame_tick), 32'd1);
  endtask

  task automatic offer(input logic [7:0] v);
    chk("offer_ready", 32'(bus.value_ready), 32'd1);
    bus.value       = v;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
    chk("offer_taken", 32'(bus.value_ready), 32'd0);
  endtask

  // Called at a frame_tick negedge; checks the following complete frame.
  task automatic frame_check(input logic [6:0] er, input logic [6:0] el, input string tag);
    int nr = 0, nl = 0, nb = 0, nt = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= SHOW + 1) begin
        if (bus.seg == er && !bus.digit_sel) nr++;
      end else if (i >= DIV + 2 && i <= DIV + SHOW + 1) begin
        if (bus.seg == el && bus.digit_sel) nl++;
      end else if (bus.seg == 7'h00) begin
        nb++;
      end
      if (bus.frame_tick) nt += (i == FRAME) ? 1 : 100;
    end
    chk({tag, "_right"}, 32'(nr), 32'(SHOW));
    chk({tag, "_left"},  32'(nl), 32'(SHOW));
    chk({tag, "_blank"}, 32'(nb), 32'(FRAME - 2 * SHOW));
    chk({tag, "_tick"},  32'(nt), 32'd1);
  endtask

  typedef struct {
    logic [7:0] value;
    logic [6:0] exp_r;
    logic [6:0] exp_l;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n, nt, nls, nlb, nexp, p;
    bit show;

    vecs[0] = '{8'h30, 7'h3F, 7'h4F};
    vecs[1] = '{8'h5B, 7'h7C, 7'h6D};
    vecs[2] = '{8'hE6, 7'h7D, 7'h79};
    vecs[3] = '{8'hC2, 7'h5B, 7'h39};
    vecs[4] = '{8'h7D, 7'h5E, 7'h07};
    vecs[5] = '{8'h94, 7'h66, 7'h6F};
    vecs[6] = '{8'h81, 7'h06, 7'h7F};

    bus.enable = 1'b0; bus.brightness = 4'd15; bus.value = 8'h00; bus.value_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state and capture/apply while idle
    reset = 1'b0; bus.value = 8'h81; bus.value_valid = 1'b1;
    #1;
    chk("t1_ready_after_reset", 32'(bus.value_ready), 32'd1);
    chk("t1_seg_reset",         32'(bus.seg),         32'd0);
    chk("t1_busy_reset",        32'(bus.busy),        32'd0);
    chk("t1_dig_reset",         32'(bus.digit_sel),   32'd0);
    @(negedge clk);
    chk("t1_ready_captured", 32'(bus.value_ready), 32'd0);
    bus.value_valid = 1'b0;
    @(negedge clk);
    chk("t1_ready_applied", 32'(bus.value_ready), 32'd1);

    // Table-driven scan of every vector, one full frame each
    bus.enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      offer(vecs[k].value);
      wait_tick();
      frame_check(vecs[k].exp_r, vecs[k].exp_l, $sformatf("vec%0d", k));
    end

    // Frame-boundary update, second offer refused while one is pending
    n = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (i == 20) begin bus.value = 8'hAF; bus.value_valid = 1'b1; end
      if (i == 21) begin
        chk("t3_captured", 32'(bus.value_ready), 32'd0);
        bus.value = 8'h55;
      end
      if (i >= 21 && i <= DIV + SHOW + 1 && bus.seg == 7'h7F) n++;
    end
    chk("t3_old_value_held",  32'(n),                9);
    chk("t3_tick",            32'(bus.frame_tick),   32'd1);
    chk("t3_second_refused",  32'(bus.value_ready),  32'd0);
    bus.value_valid = 1'b0;
    frame_check(7'h71, 7'h77, "t3_new");
    chk("t3_ready_free", 32'(bus.value_ready), 32'd1);

    // Brightness 0: lit only on the PWM-zero cycle of SHOW slots
    bus.brightness = 4'd0;
    wait_tick();
    nls = 0; nlb = 0; nexp = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      p    = (i - 1) % FRAME + 1;
      show = (p >= 2 && p <= SHOW + 1) || (p >= DIV + 2 && p <= DIV + SHOW + 1);
      if (show) begin
        if (bus.seg != 7'h00) nls++;
        if (m_pwm == 1) nexp++;
      end else if (bus.seg != 7'h00) begin
        nlb++;
      end
    end
    chk("t4_lit_show",  32'(nls), 32'(nexp));
    chk("t4_lit_blank", 32'(nlb), 32'd0);
    bus.brightness = 4'd15;

    // Enable drop in SHOW_L, then re-enable
    repeat (20) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("t5_busy_drop", 32'(bus.busy),       32'd0);
    chk("t5_no_tick",   32'(bus.frame_tick), 32'd0);
    @(negedge clk);
    chk("t5_seg_off", 32'(bus.seg),       32'd0);
    chk("t5_dig_off", 32'(bus.digit_sel), 32'd0);
    nt = 0;
    repeat (20) begin
      @(negedge clk);
      nt += int'(bus.frame_tick);
    end
    chk("t5_idle_ticks", 32'(nt), 32'd0);
    bus.enable = 1'b1;
    n = 0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("t5_busy_restart", 32'(bus.busy), 32'd1);
        chk("t5_seg_restart",  32'(bus.seg),  32'd0);
      end
      if (j >= 2 && j <= SHOW + 1 && bus.seg == 7'h71 && !bus.digit_sel) n++;
      if (j == SHOW + 2) chk("t5_slot_end_blank", 32'(bus.seg), 32'd0);
    end
    chk("t5_full_slot", 32'(n), 32'(SHOW));

    // Randomised traffic against the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.enable      = ($urandom_range(0, 99) < 99);
      bus.value_valid = ($urandom_range(0, 3) == 0);
      bus.value       = 8'($urandom);
      if ($urandom_range(0, 63) == 0) bus.brightness = 4'($urandom_range(0, 15));
    end

    // Async reset mid SHOW_L with a pending value
    @(negedge clk);
    bus.enable = 1'b1; bus.value_valid = 1'b0; bus.brightness = 4'd15;
    wait_tick();
    wait_tick();
    repeat (18) @(negedge clk);
    chk("t6_ready_before", 32'(bus.value_ready), 32'd1);
    bus.value = 8'h3C; bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
    chk("t6_pend_full", 32'(bus.value_ready),     32'd0);
    chk("t6_left",      32'(bus.digit_sel),       32'd1);
    chk("t6_lit",       32'(bus.seg != 7'h00),    32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_seg_async",   32'(bus.seg),         32'd0);
    chk("t6_dig_async",   32'(bus.digit_sel),   32'd0);
    chk("t6_ready_async", 32'(bus.value_ready), 32'd1);
    chk("t6_busy_async",  32'(bus.busy),        32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
